// File: rtl/mem_stage_pkg.sv
// Shared MEM-stage types: FSM states, write-back select codes
// and the MEM/WB bundle.
package mem_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  localparam logic [1:0] MEMTOREG_ALU  = 2'b00;
  localparam logic [1:0] MEMTOREG_LOAD = 2'b01;
  localparam logic [1:0] MEMTOREG_LINK = 2'b10;
  localparam logic [1:0] MEMTOREG_RSVD = 2'b11;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [REG_W-1:0]  rd;
    logic              regwrite;
  } mem_wb_t;

  function automatic logic [DATA_W-1:0] wb_select(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] alu,
    input logic [DATA_W-1:0] load
  );
    logic [DATA_W-1:0] res;
    res = '0;
    unique case (sel)
      MEMTOREG_ALU:  res = alu;
      MEMTOREG_LOAD: res = load;
      MEMTOREG_LINK: res = alu;
      MEMTOREG_RSVD: res = '0;
      default:       res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack port; the stage is master,
// the memory is slave.
interface mem_access_stage_if;
  import mem_stage_pkg::*;

  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_ack,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_ack,
    output dmem_rdata
  );

endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register; loads a bubble while
// the stage is stalled.
module mem_wb_reg
  import mem_stage_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    stall,
  input  mem_wb_t d,
  output mem_wb_t q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (stall) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: req/ack data-memory access with timeout abort and
// folded MEM/WB register. Optional MEM_ALIGN_CHECK_EN.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] alu_res_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic [REG_W-1:0]  rd_in,
  input  logic [1:0]        memtoreg_in,
  input  logic              memread_in,
  input  logic              memwrite_in,
  input  logic              regwrite_in,
  mem_access_stage_if.master dmem,
  output logic              stall,
  output logic              bus_err,
`ifdef MEM_ALIGN_CHECK_EN
  output logic              misalign_err,
`endif
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_W-1:0]  wb_rd,
  output logic              wb_regwrite
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state;
  logic [CNT_W-1:0] cnt;

  logic mem_op;
  logic misalign;
  logic access;
  logic in_wait;
  logic timeout_now;
  logic ack;

  mem_wb_t wb_next;
  mem_wb_t wb_q;

  assign ack    = dmem.dmem_ack;
  assign mem_op = memread_in | memwrite_in;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = mem_op & (alu_res_in[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign access  = mem_op & ~misalign;
  assign in_wait = (state == S_WAIT);

  assign timeout_now = in_wait & ~ack & (cnt == CNT_LAST);

  // Gated by rst so an in-flight request drops at once.
  assign dmem.dmem_req   = rst & ((~in_wait & access) | in_wait);
  assign dmem.dmem_we    = rst & memwrite_in;
  assign dmem.dmem_addr  = alu_res_in;
  assign dmem.dmem_wdata = wdata_in;

  assign stall = rst & access & ~ack & ~timeout_now;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bus_err <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_err <= 1'b0;
`endif
    end else begin
      bus_err <= timeout_now;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_err <= misalign;
`endif
      unique case (state)
        S_IDLE: begin
          if (access && !ack) begin
            state <= S_WAIT;
            cnt   <= CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (ack || timeout_now) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Load data only exists in the ack cycle; a timed-out load writes 0.
  always_comb begin
    wb_next          = '0;
    wb_next.rd       = rd_in;
    wb_next.data     = wb_select(memtoreg_in, alu_res_in,
                         ack ? dmem.dmem_rdata : '0);
    wb_next.regwrite = regwrite_in
                     & ~(timeout_now & memread_in)
                     & ~misalign;
  end

  mem_wb_reg u_mem_wb_reg (
    .clk   (clk),
    .rst   (rst),
    .stall (stall),
    .d     (wb_next),
    .q     (wb_q)
  );

  assign wb_data     = wb_q.data;
  assign wb_rd       = wb_q.rd;
  assign wb_regwrite = wb_q.regwrite;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomised self-checking bench for mem_access_stage against
// a transaction-level model of the stage.
module tb_mem_access_stage;
  import mem_stage_pkg::*;

  localparam int T = 4;

  logic        clk;
  logic        rst;
  logic [31:0] alu_res_in;
  logic [31:0] wdata_in;
  logic [4:0]  rd_in;
  logic [1:0]  memtoreg_in;
  logic        memread_in;
  logic        memwrite_in;
  logic        regwrite_in;
  logic        stall;
  logic        bus_err;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_regwrite;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misalign_err;
`endif

  int compared;
  int mismatched;

  mem_access_stage_if dmem ();

  mem_access_stage #(
    .TIMEOUT_CYCLES (T),
    .CNT_W          (5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_res_in   (alu_res_in),
    .wdata_in     (wdata_in),
    .rd_in        (rd_in),
    .memtoreg_in  (memtoreg_in),
    .memread_in   (memread_in),
    .memwrite_in  (memwrite_in),
    .regwrite_in  (regwrite_in),
    .dmem         (dmem.master),
    .stall        (stall),
    .bus_err      (bus_err),
`ifdef MEM_ALIGN_CHECK_EN
    .misalign_err (misalign_err),
`endif
    .wb_data      (wb_data),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [1:0]  m2r;
    logic        rd_en;
    logic        wr;
    logic        rw;
  } instr_t;

  typedef struct {
    int          stalls;
    int          reqs;
    bit          we_ok;
    bit          bubble_ok;
    bit          hung;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        rw;
    logic        berr;
    logic        merr;
  } obs_t;

  typedef struct {
    int          stalls;
    int          reqs;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        rw;
    logic        berr;
    logic        merr;
  } exp_t;

  // Transaction-level expectation: how long the instruction sits in
  // the stage and what it hands to write-back.
  function automatic exp_t model(input instr_t i, input int lat,
                                 input logic [31:0] rdat);
    exp_t e;
    bit op, mis, acc, acked;
    op = i.rd_en || i.wr;
`ifdef MEM_ALIGN_CHECK_EN
    mis = op && (i.addr[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    acc   = op && !mis;
    acked = acc && lat >= 0 && lat < T;
    e.berr   = acc && !acked;
    e.merr   = mis;
    e.stalls = !acc ? 0 : (acked ? lat : T - 1);
    e.reqs   = acc ? e.stalls + 1 : 0;
    e.rw     = i.rw && !(e.berr && i.rd_en) && !mis;
    e.rd     = i.rd;
    if (i.m2r == 2'd0 || i.m2r == 2'd2) e.data = i.addr;
    else if (i.m2r == 2'd1) e.data = acked ? rdat : 32'd0;
    else e.data = 32'd0;
    return e;
  endfunction

  // Entered at posedge+1; returns at posedge+1 after the instruction
  // leaves the stage. The memory acks in cycle 'lat' if requested.
  task automatic drive_instr(input instr_t i, input int lat,
                             input logic [31:0] rdat, output obs_t o);
    bit done;
    logic st;
    o.stalls = 0; o.reqs = 0; o.we_ok = 1; o.bubble_ok = 1;
    o.hung = 0; o.data = 'x; o.rd = 'x; o.rw = 'x;
    o.berr = 'x; o.merr = 'x;
    done = 0;
    alu_res_in  = i.addr;
    wdata_in    = i.wdata;
    rd_in       = i.rd;
    memtoreg_in = i.m2r;
    memread_in  = i.rd_en;
    memwrite_in = i.wr;
    regwrite_in = i.rw;
    for (int c = 0; c < 64 && !done; c++) begin
      #1;
      dmem.dmem_ack   = dmem.dmem_req && (c == lat);
      dmem.dmem_rdata = dmem.dmem_ack ? rdat : $urandom;
      #2;
      if (dmem.dmem_req === 1'b1) begin
        o.reqs++;
        if (dmem.dmem_we !== (i.wr === 1'b1)) o.we_ok = 0;
      end
      st = stall;
      @(posedge clk);
      #1;
      dmem.dmem_ack = 1'b0;
      if (st !== 1'b1) begin
        done = 1;
        o.data = wb_data;
        o.rd   = wb_rd;
        o.rw   = wb_regwrite;
        o.berr = bus_err;
`ifdef MEM_ALIGN_CHECK_EN
        o.merr = misalign_err;
`else
        o.merr = 1'b0;
`endif
      end else begin
        o.stalls++;
        if (wb_regwrite !== 1'b0 || bus_err !== 1'b0) o.bubble_ok = 0;
      end
    end
    if (!done) o.hung = 1;
  endtask

  function automatic instr_t mk(input logic [31:0] a, input logic [31:0] w,
                                input logic [4:0] r, input logic [1:0] m,
                                input logic rd_en, input logic wr,
                                input logic rw);
    instr_t i;
    i.addr = a; i.wdata = w; i.rd = r; i.m2r = m;
    i.rd_en = rd_en; i.wr = wr; i.rw = rw;
    return i;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    alu_res_in = 32'h40; wdata_in = '0; rd_in = 5'd3;
    memtoreg_in = 2'b01; memread_in = 1'b1; memwrite_in = 1'b0;
    regwrite_in = 1'b1;
    dmem.dmem_ack = 1'b0; dmem.dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #4;
    compared++;
    if (dmem.dmem_req !== 1'b0 || stall !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_req_stall: req=%b stall=%b required 0 0",
               dmem.dmem_req, stall);
    end
    compared++;
    if (wb_data !== 32'd0 || wb_rd !== 5'd0 || wb_regwrite !== 1'b0 ||
        bus_err !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_outputs: data=%h rd=%0d rw=%b berr=%b required 0",
               wb_data, wb_rd, wb_regwrite, bus_err);
    end
    memread_in = 1'b0; regwrite_in = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_zero_wait_load();
    instr_t i;
    obs_t o;
    i = mk(32'h40, 32'h0, 5'd5, 2'b01, 1'b1, 1'b0, 1'b1);
    drive_instr(i, 0, 32'hDEADBEEF, o);
    compared++;
    if (o.stalls !== 0 || o.reqs !== 1) begin
      mismatched++;
      $display("FAIL zw_load_timing: stalls=%0d reqs=%0d required 0 1",
               o.stalls, o.reqs);
    end
    compared++;
    if (o.data !== 32'hDEADBEEF || o.rd !== 5'd5 || o.rw !== 1'b1) begin
      mismatched++;
      $display("FAIL zw_load_wb: data=%h rd=%0d rw=%b required deadbeef 5 1",
               o.data, o.rd, o.rw);
    end
  endtask

  task automatic test_wait_store();
    instr_t i;
    obs_t o;
    i = mk(32'h80, 32'h1234, 5'd7, 2'b00, 1'b0, 1'b1, 1'b0);
    drive_instr(i, 3, 32'h0, o);
    compared++;
    if (o.stalls !== 3 || o.reqs !== 4 || !o.we_ok) begin
      mismatched++;
      $display("FAIL store_wait: stalls=%0d reqs=%0d we_ok=%b required 3 4 1",
               o.stalls, o.reqs, o.we_ok);
    end
    compared++;
    if (!o.bubble_ok || o.rw !== 1'b0 || o.berr !== 1'b0) begin
      mismatched++;
      $display("FAIL store_wb: bubble_ok=%b rw=%b berr=%b required 1 0 0",
               o.bubble_ok, o.rw, o.berr);
    end
  endtask

  task automatic test_timeout();
    instr_t i;
    obs_t o;
    i = mk(32'h100, 32'h0, 5'd9, 2'b01, 1'b1, 1'b0, 1'b1);
    drive_instr(i, -1, 32'h0, o);
    compared++;
    if (o.stalls !== T - 1 || o.reqs !== T) begin
      mismatched++;
      $display("FAIL timeout_timing: stalls=%0d reqs=%0d required %0d %0d",
               o.stalls, o.reqs, T - 1, T);
    end
    compared++;
    if (o.berr !== 1'b1 || o.rw !== 1'b0 || o.data !== 32'd0) begin
      mismatched++;
      $display("FAIL timeout_wb: berr=%b rw=%b data=%h required 1 0 0",
               o.berr, o.rw, o.data);
    end
    i = mk(32'h0, 32'h0, 5'd1, 2'b00, 1'b0, 1'b0, 1'b0);
    drive_instr(i, -1, 32'h0, o);
    compared++;
    if (o.berr !== 1'b0 || o.reqs !== 0) begin
      mismatched++;
      $display("FAIL timeout_pulse: berr=%b reqs=%0d required 0 0",
               o.berr, o.reqs);
    end
  endtask

  task automatic test_ack_at_timeout();
    instr_t i;
    obs_t o;
    i = mk(32'h200, 32'h0, 5'd11, 2'b01, 1'b1, 1'b0, 1'b1);
    drive_instr(i, T - 1, 32'hCAFEF00D, o);
    compared++;
    if (o.stalls !== T - 1 || o.berr !== 1'b0) begin
      mismatched++;
      $display("FAIL ack_at_timeout_err: stalls=%0d berr=%b required %0d 0",
               o.stalls, o.berr, T - 1);
    end
    compared++;
    if (o.data !== 32'hCAFEF00D || o.rw !== 1'b1 || o.rd !== 5'd11) begin
      mismatched++;
      $display("FAIL ack_at_timeout_wb: data=%h rw=%b rd=%0d required cafef00d 1 11",
               o.data, o.rw, o.rd);
    end
  endtask

  task automatic test_reset_mid_wait();
    instr_t i;
    obs_t o;
    alu_res_in = 32'h300; wdata_in = 32'h0; rd_in = 5'd13;
    memtoreg_in = 2'b01; memread_in = 1'b1; memwrite_in = 1'b0;
    regwrite_in = 1'b1; dmem.dmem_ack = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst = 1'b0;
    #1;
    compared++;
    if (dmem.dmem_req !== 1'b0 || stall !== 1'b0 || bus_err !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_mid_req: req=%b stall=%b berr=%b required 0 0 0",
               dmem.dmem_req, stall, bus_err);
    end
    compared++;
    if (wb_data !== 32'd0 || wb_rd !== 5'd0 || wb_regwrite !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_mid_wb: data=%h rd=%0d rw=%b required 0 0 0",
               wb_data, wb_rd, wb_regwrite);
    end
    memread_in = 1'b0; regwrite_in = 1'b0;
    @(posedge clk);
    #4;
    rst = 1'b1;
    #1;
    compared++;
    if (dmem.dmem_req !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_mid_idle: req=%b required 0", dmem.dmem_req);
    end
    @(posedge clk);
    #1;
    i = mk(32'h44, 32'h0, 5'd2, 2'b01, 1'b1, 1'b0, 1'b1);
    drive_instr(i, 1, 32'h5A5A5A5A, o);
    compared++;
    if (o.stalls !== 1 || o.data !== 32'h5A5A5A5A || o.rw !== 1'b1) begin
      mismatched++;
      $display("FAIL rst_mid_after: stalls=%0d data=%h rw=%b required 1 5a5a5a5a 1",
               o.stalls, o.data, o.rw);
    end
  endtask

`ifdef MEM_ALIGN_CHECK_EN
  task automatic test_misalign();
    instr_t i;
    obs_t o;
    i = mk(32'h42, 32'h0, 5'd6, 2'b01, 1'b1, 1'b0, 1'b1);
    drive_instr(i, 0, 32'h1111, o);
    compared++;
    if (o.reqs !== 0 || o.stalls !== 0) begin
      mismatched++;
      $display("FAIL misalign_req: reqs=%0d stalls=%0d required 0 0",
               o.reqs, o.stalls);
    end
    compared++;
    if (o.merr !== 1'b1 || o.rw !== 1'b0) begin
      mismatched++;
      $display("FAIL misalign_wb: merr=%b rw=%b required 1 0", o.merr, o.rw);
    end
  endtask
`endif

  task automatic test_random(input int n);
    instr_t i;
    obs_t o;
    exp_t e;
    int lat;
    logic [31:0] rdat;
    for (int k = 0; k < n; k++) begin
      i.addr  = $urandom;
      i.wdata = $urandom;
      i.rd    = 5'($urandom);
      i.m2r   = 2'($urandom);
      i.rd_en = 1'($urandom);
      i.wr    = 1'($urandom);
      i.rw    = 1'($urandom);
      lat     = $urandom_range(0, T + 1);
      if (lat == T + 1) lat = -1;
      rdat    = $urandom;
      e = model(i, lat, rdat);
      drive_instr(i, lat, rdat, o);
      compared++;
      if (o.hung || o.stalls !== e.stalls || o.reqs !== e.reqs) begin
        mismatched++;
        $display("FAIL rand_timing[%0d]: stalls=%0d reqs=%0d required %0d %0d",
                 k, o.stalls, o.reqs, e.stalls, e.reqs);
      end
      compared++;
      if (!o.we_ok || !o.bubble_ok) begin
        mismatched++;
        $display("FAIL rand_hold[%0d]: we_ok=%b bubble_ok=%b required 1 1",
                 k, o.we_ok, o.bubble_ok);
      end
      compared++;
      if (o.data !== e.data || o.rd !== e.rd || o.rw !== e.rw) begin
        mismatched++;
        $display("FAIL rand_wb[%0d]: data=%h rd=%0d rw=%b required %h %0d %b",
                 k, o.data, o.rd, o.rw, e.data, e.rd, e.rw);
      end
      compared++;
      if (o.berr !== e.berr || o.merr !== e.merr) begin
        mismatched++;
        $display("FAIL rand_err[%0d]: berr=%b merr=%b required %b %b",
                 k, o.berr, o.merr, e.berr, e.merr);
      end
    end
  endtask

  task automatic test_back_to_back(input int n);
    instr_t i;
    obs_t o;
    exp_t e;
    logic [31:0] rdat;
    for (int k = 0; k < n; k++) begin
      i = mk({$urandom} & 32'hFFFF_FFFC, $urandom, 5'($urandom),
             2'b01, 1'b1, 1'b0, 1'b1);
      rdat = $urandom;
      e = model(i, 0, rdat);
      drive_instr(i, 0, rdat, o);
      compared++;
      if (o.stalls !== 0 || o.data !== e.data || o.rd !== e.rd ||
          o.rw !== 1'b1) begin
        mismatched++;
        $display("FAIL b2b[%0d]: stalls=%0d data=%h rd=%0d rw=%b required 0 %h %0d 1",
                 k, o.stalls, o.data, o.rd, o.rw, e.data, e.rd);
      end
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_zero_wait_load();
    test_wait_store();
    test_timeout();
    test_ack_at_timeout();
    test_reset_mid_wait();
`ifdef MEM_ALIGN_CHECK_EN
    test_misalign();
`endif
    test_back_to_back(8);
    test_random(300);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
